// File: rtl/ps2_mouse_dev_ctrl.sv
`default_nettype none
// ps2_mouse_dev_ctrl -- PS/2 mouse device command interpreter and movement reporter (rev 1.0).
// Define PS2_MOUSE_WHEEL_EN to enable the C8/64/50 wheel unlock (ID 03, 4-byte packets).
module ps2_mouse_dev_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned MOV_W       = 8,
  parameter logic [7:0]  DEVICE_ID   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic [7:0]              tx_data,
  output logic                    tx_stb,
  input  logic                    tx_ready,
  input  logic                    tx_done,
  input  logic                    mv_valid,
  input  logic signed [MOV_W-1:0] mv_dx,
  input  logic signed [MOV_W-1:0] mv_dy,
  input  logic signed [3:0]       mv_dz,
  input  logic [2:0]              btn,
  output logic                    stream_mode,
  output logic                    report_en,
  output logic [7:0]              cur_id
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACK       = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_RESP      = 3'd3;
  localparam logic [2:0] S_WAIT_RESP = 3'd4;
  localparam logic [2:0] S_PKT       = 3'd5;
  localparam logic [2:0] S_WAIT_PKT  = 3'd6;
  localparam logic [2:0] S_GET_ARG   = 3'd7;

  localparam logic [1:0] ARG_NONE = 2'd0;
  localparam logic [1:0] ARG_RATE = 2'd1;
  localparam logic [1:0] ARG_RES  = 2'd2;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_BAT    = 8'hAA;
  localparam logic [7:0] RATE_DEF    = 8'd100;

  function automatic logic rate_ok(input logic [7:0] r);
    return (r == 8'd10) || (r == 8'd20) || (r == 8'd40) || (r == 8'd60) ||
           (r == 8'd80) || (r == 8'd100) || (r == 8'd200);
  endfunction

  function automatic logic [31:0] reload_for(input logic [7:0] r);
    logic [31:0] v;
    case (r)
      8'd10:   v = CLK_FREQ_HZ / 10 - 1;
      8'd20:   v = CLK_FREQ_HZ / 20 - 1;
      8'd40:   v = CLK_FREQ_HZ / 40 - 1;
      8'd60:   v = CLK_FREQ_HZ / 60 - 1;
      8'd80:   v = CLK_FREQ_HZ / 80 - 1;
      8'd200:  v = CLK_FREQ_HZ / 200 - 1;
      default: v = CLK_FREQ_HZ / 100 - 1;
    endcase
    return v;
  endfunction

  // Returns {overflow, saturated 9-bit value}.
  function automatic logic [9:0] sat9(input logic signed [10:0] v);
    if (v > 11'sd255)  return {1'b1, 9'h0FF};
    if (v < -11'sd256) return {1'b1, 9'h100};
    return {1'b0, v[8:0]};
  endfunction

  logic [2:0]        state_q, state_d;
  logic [3:0][7:0]   resp_q, resp_d;
  logic [2:0]        len_q, len_d, nidx;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d, last_tx_q, last_tx_d;
  logic              pkt_pend_q, pkt_pend_d;
  logic [1:0]        arg_q, arg_d;
  logic              stream_q, stream_d, report_q, report_d, scaling_q, scaling_d;
  logic [1:0]        res_q, res_d;
  logic [7:0]        rate_q, rate_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              tick, tick_pend_q, tick_pend_d;
  logic signed [8:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, base_x, base_y;
  logic              ov_x_q, ov_x_d, ov_y_q, ov_y_d;
  logic [9:0]        sx, sy;
  logic [2:0]        btn_q, btn_d, btn_sent_q, btn_sent_d;
  logic              snap, set_def, rate_acc, acc_nz, wheel_pkt, z_nz;
  logic [7:0]        pkt0, byte4;

  assign tx_stb      = tx_ready && (state_q == S_ACK || state_q == S_RESP || state_q == S_PKT);
  assign tx_data     = tx_data_q;
  assign stream_mode = stream_q;
  assign report_en   = report_q;
  assign pkt0        = {ov_y_q, ov_x_q, acc_y_q[8], acc_x_q[8], 1'b1, btn_q};
  assign acc_nz      = (acc_x_q != 9'sd0) || (acc_y_q != 9'sd0) || z_nz;

  // A snapshot clears the accumulators; same-cycle movement lands in the cleared values.
  always_comb begin
    base_x     = snap ? 9'sd0 : acc_x_q;
    base_y     = snap ? 9'sd0 : acc_y_q;
    sx         = sat9(11'(base_x) + 11'(mv_dx));
    sy         = sat9(11'(base_y) + 11'(mv_dy));
    acc_x_d    = mv_valid ? sx[8:0] : base_x;
    acc_y_d    = mv_valid ? sy[8:0] : base_y;
    ov_x_d     = (!snap && ov_x_q) || (mv_valid && sx[9]);
    ov_y_d     = (!snap && ov_y_q) || (mv_valid && sy[9]);
    btn_d      = mv_valid ? btn : btn_q;
    btn_sent_d = snap ? btn_q : btn_sent_q;
  end

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    pkt_pend_d  = pkt_pend_q;
    arg_d       = arg_q;
    stream_d    = stream_q;
    report_d    = report_q;
    scaling_d   = scaling_q;
    res_d       = res_q;
    rate_d      = rate_q;
    tick        = (cnt_q == 32'd0);
    cnt_d       = tick ? reload_for(rate_q) : cnt_q - 32'd1;
    tick_pend_d = tick_pend_q || tick;
    last_tx_d   = tx_stb ? tx_data_q : last_tx_q;
    snap        = 1'b0;
    set_def     = 1'b0;
    rate_acc    = 1'b0;
    nidx        = {1'b0, idx_q} + 3'd1;

    if (rx_done && state_q == S_GET_ARG) begin
      state_d   = S_ACK;
      arg_d     = ARG_NONE;
      tx_data_d = BYTE_ACK;
      if (arg_q == ARG_RATE) begin
        if (rate_ok(rx_data)) begin
          rate_d   = rx_data;
          cnt_d    = reload_for(rx_data);
          rate_acc = 1'b1;
        end else begin
          tx_data_d = BYTE_RESEND;
        end
      end else if (rx_data < 8'd4) begin
        res_d = rx_data[1:0];
      end else begin
        tx_data_d = BYTE_RESEND;
      end
    end else if (rx_done) begin
      // Any pending response or unsnapshot packet is abandoned here.
      state_d    = S_ACK;
      len_d      = 3'd0;
      idx_d      = 2'd0;
      pkt_pend_d = 1'b0;
      arg_d      = ARG_NONE;
      tx_data_d  = BYTE_ACK;
      case (rx_data)
        8'hFF, 8'hF6: begin
          set_def   = 1'b1;
          stream_d  = 1'b1;
          report_d  = 1'b0;
          scaling_d = 1'b0;
          res_d     = 2'd2;
          rate_d    = RATE_DEF;
          cnt_d     = reload_for(RATE_DEF);
          if (rx_data == 8'hFF) begin
            resp_d[0] = BYTE_BAT;
            resp_d[1] = DEVICE_ID;
            len_d     = 3'd2;
          end
        end
        8'hF5: report_d = 1'b0;
        8'hF4: report_d = 1'b1;
        8'hF2: begin
          resp_d[0] = cur_id;
          len_d     = 3'd1;
        end
        8'hF0: stream_d = 1'b0;
        8'hEA: stream_d = 1'b1;
        8'hEB: pkt_pend_d = 1'b1;
        8'hE9: begin
          resp_d[0] = {1'b0, ~stream_q, report_q, scaling_q, 1'b0, btn_q};
          resp_d[1] = {6'd0, res_q};
          resp_d[2] = rate_q;
          len_d     = 3'd3;
        end
        8'hE6: scaling_d = 1'b0;
        8'hE7: scaling_d = 1'b1;
        8'hF3: arg_d = ARG_RATE;
        8'hE8: arg_d = ARG_RES;
        8'hFE: tx_data_d = last_tx_d;
        default: tx_data_d = BYTE_RESEND;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          tick_pend_d = 1'b0;
          if ((tick || tick_pend_q) && report_q && stream_q && (acc_nz || btn_q != btn_sent_q))
            snap = 1'b1;
        end
        // Each send state is immediately followed by its wait state in the encoding.
        S_ACK, S_RESP, S_PKT: if (tx_ready) state_d = state_q + 3'd1;
        S_WAIT_ACK: if (tx_done) begin
          if (len_q != 3'd0) begin
            state_d   = S_RESP;
            idx_d     = 2'd0;
            tx_data_d = resp_q[0];
          end else if (pkt_pend_q) begin
            pkt_pend_d = 1'b0;
            snap       = 1'b1;
          end else if (arg_q != ARG_NONE) begin
            state_d = S_GET_ARG;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_RESP, S_WAIT_PKT: if (tx_done) begin
          if (nidx < len_q) begin
            idx_d     = nidx[1:0];
            tx_data_d = resp_q[nidx[1:0]];
            state_d   = state_q - 3'd1;
          end else begin
            state_d = S_IDLE;
            len_d   = 3'd0;
          end
        end
        default: ;
      endcase
      if (snap) begin
        resp_d    = {byte4, acc_y_q[7:0], acc_x_q[7:0], pkt0};
        len_d     = wheel_pkt ? 3'd4 : 3'd3;
        idx_d     = 2'd0;
        tx_data_d = pkt0;
        state_d   = S_PKT;
      end
    end
  end

`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]        id_q, id_d;
  logic [1:0]        seq_q, seq_d;
  logic signed [3:0] acc_z_q, acc_z_d, base_z;
  logic signed [4:0] sz;

  assign cur_id    = id_q;
  assign wheel_pkt = (id_q == 8'h03);
  assign byte4     = {{4{acc_z_q[3]}}, acc_z_q};
  assign z_nz      = (acc_z_q != 4'sd0);

  always_comb begin
    id_d   = id_q;
    seq_d  = seq_q;
    base_z = snap ? 4'sd0 : acc_z_q;
    sz     = 5'(base_z) + 5'(mv_dz);
    if (!mv_valid)           acc_z_d = base_z;
    else if (sz > 5'sd7)     acc_z_d = 4'sd7;
    else if (sz < -5'sd8)    acc_z_d = -4'sd8;
    else                     acc_z_d = sz[3:0];
    if (set_def) begin
      id_d  = DEVICE_ID;
      seq_d = 2'd0;
    end else if (rate_acc) begin
      if (rx_data == 8'hC8)                       seq_d = 2'd1;
      else if (rx_data == 8'h64 && seq_q == 2'd1) seq_d = 2'd2;
      else if (rx_data == 8'h50 && seq_q == 2'd2) begin
        seq_d = 2'd0;
        id_d  = 8'h03;
      end else                                    seq_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= DEVICE_ID;
      seq_q   <= 2'd0;
      acc_z_q <= 4'sd0;
    end else begin
      id_q    <= id_d;
      seq_q   <= seq_d;
      acc_z_q <= acc_z_d;
    end
  end
`else
  logic unused_wheel;
  assign unused_wheel = ^{mv_dz, set_def, rate_acc};
  assign cur_id       = DEVICE_ID;
  assign wheel_pkt    = 1'b0;
  assign byte4        = 8'h00;
  assign z_nz         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      resp_q      <= '0;
      len_q       <= 3'd0;
      idx_q       <= 2'd0;
      tx_data_q   <= 8'h00;
      last_tx_q   <= 8'h00;
      pkt_pend_q  <= 1'b0;
      arg_q       <= ARG_NONE;
      stream_q    <= 1'b1;
      report_q    <= 1'b0;
      scaling_q   <= 1'b0;
      res_q       <= 2'd2;
      rate_q      <= RATE_DEF;
      cnt_q       <= 32'd0;
      tick_pend_q <= 1'b0;
      acc_x_q     <= 9'sd0;
      acc_y_q     <= 9'sd0;
      ov_x_q      <= 1'b0;
      ov_y_q      <= 1'b0;
      btn_q       <= 3'd0;
      btn_sent_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      last_tx_q   <= last_tx_d;
      pkt_pend_q  <= pkt_pend_d;
      arg_q       <= arg_d;
      stream_q    <= stream_d;
      report_q    <= report_d;
      scaling_q   <= scaling_d;
      res_q       <= res_d;
      rate_q      <= rate_d;
      cnt_q       <= cnt_d;
      tick_pend_q <= tick_pend_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      ov_x_q      <= ov_x_d;
      ov_y_q      <= ov_y_d;
      btn_q       <= btn_d;
      btn_sent_q  <= btn_sent_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/ps2_mouse_dev_ctrl.md
# ps2_mouse_dev_ctrl

Parametrised PS/2 mouse device controller for the check_fractal_mouse bench and FPGA mouse emulation. It sits between the byte-level `ps2_device_rx`/`ps2_device_tx` engines and a movement source. It interprets the full host command set, accumulates movement between reports, and emits 3- or 4-byte packets at the programmed sample rate in stream mode, or on demand in remote mode.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: clk frequency; sets the report interval.
- `MOV_W`, 8: width of signed `mv_dx`/`mv_dy` inputs (2..9).
- `DEVICE_ID`, 8'h00: base device ID.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: host byte from rx engine.
- `rx_done` in 1: 1-cycle pulse, `rx_data` valid.
- `tx_data` out 8: byte to tx engine.
- `tx_stb` out 1: 1-cycle send strobe.
- `tx_ready` in 1: tx engine idle.
- `tx_done` in 1: 1-cycle pulse, byte sent.
- `mv_valid` in 1: accumulate `mv_dx`/`mv_dy`/`mv_dz`/`btn` this cycle.
- `mv_dx`, `mv_dy` in MOV_W: signed deltas.
- `mv_dz` in 4: signed wheel delta.
- `btn` in 3: {middle, right, left}.
- `stream_mode` out 1; `report_en` out 1; `cur_id` out 8: live configuration.

## Operation
- States: IDLE, ACK, WAIT_ACK, RESP, WAIT_RESP, PKT, WAIT_PKT, GET_ARG.
- `tx_stb` is asserted only in ACK/RESP/PKT with `tx_ready`=1. The next byte waits for `tx_done`.
- Responses are queued in a 4-entry byte buffer. A byte index walks it.
- Commands:
  - FF: ACK, AA, `cur_id`; then defaults.
  - F6: ACK; defaults.
  - F5: ACK; report_en=0.
  - F4: ACK; report_en=1.
  - F2: ACK, `cur_id`.
  - F0: ACK; remote mode.
  - EA: ACK; stream mode.
  - EB: ACK + packet.
  - E9: ACK + status {0,remote,report_en,scaling21,0,btn m,r,l}, resolution, rate.
  - E6/E7: ACK; scaling 1:1/2:1 (stored only).
  - F3/E8: ACK, then GET_ARG. The next `rx_done` is the argument; ACK it.
  - FE: resend the last transmitted byte.
  - Other: reply FE.
- Valid F3 rates: 10,20,40,60,80,100,200. Any other rate gets FE and the old rate is kept. E8 args 0..3, else FE.
- Defaults: stream mode, report_en=0, rate 100, resolution 2, scaling 1:1, `cur_id`=DEVICE_ID.
- Accumulators are 9-bit signed and saturate at −256/+255; saturation sets a sticky x_ov/y_ov. The wheel accumulator is 4-bit signed, saturating at −8/+7.
- A packet snapshots the accumulators and clears them in the same cycle; a `mv_valid` arriving that cycle lands in the cleared accumulators.
- Byte1 = {y_ov,x_ov,dy[8],dx[8],1,m,r,l}, byte2 = dx[7:0], byte3 = dy[7:0]. Byte4 = sign-extended dz, sent only when `cur_id`=03.
- Stream report fires at an interval tick if report_en, stream mode, FSM IDLE, and (nonzero accumulator or button change since the last packet).

## Timing
- Reset values: tx_stb=0, tx_data=00, stream_mode=1, report_en=0, cur_id=DEVICE_ID, accumulators 0, interval counter 0, FSM IDLE.
- ACK strobe: 1 cycle after `rx_done` if `tx_ready`, else the first cycle `tx_ready`=1.
- Interval counter reloads to CLK_FREQ_HZ/rate−1 on a rate change; a tick occurs on wrap to 0.
- A missed tick while busy is held pending (at most one).
- `rx_done` in any state except GET_ARG aborts a queued response or packet; the remaining bytes are dropped, and a byte already strobed is allowed to finish. Then ACK/handle; accumulators keep their values if the packet was not yet snapshot.
- `rx_done` and a tick in the same cycle: the command wins and the tick is held pending.
- Deassertion of `rst_n` mid-byte: the FSM returns to IDLE and no strobe occurs until the first clk after release.

## Configuration
- `PS2_MOUSE_WHEEL_EN` defined: the rate sequence F3 C8, F3 64, F3 50 sets `cur_id`=03 and enables 4-byte packets. FF/F6 restore DEVICE_ID.
- Undefined: sequence tracking is absent, `cur_id` stays DEVICE_ID, packets are always 3 bytes, and `mv_dz` is ignored.

## Test plan
- rst_n release, host FF → tx FA, AA, 00; stream_mode=1, report_en=0.
- F4, then mv_dx=+5, mv_dy=−3, btn=001 → after ≤10 ms (rate 100) packet 29, 05, FD.
- mv_dx=+200 applied twice before a tick → byte1 has x_ov=1, byte2=FF (saturated +255).
- F3 0F → FA then FE; status request E9 returns FA, 20, 02, 64 (rate unchanged).
- F3 C8, F3 64, F3 50, F2 (WHEEL_EN defined) → id 03; subsequent packet with mv_dz=−1 is 4 bytes, byte4=FF.
- Host F5 arrives during byte2 of a packet → byte2 completes, byte3 is dropped, FA is sent, and report_en=0.
